dmemory_port: RTL

- Data-side load/store port for the pipeline. Accepts one load or store per request over a valid/ready handshake.
- Drives the same four byte-lane single-port SRAM macros as the instruction fetch side and returns read data or a store acknowledge over a valid/ready response channel.
- Handles byte, halfword and word accesses, including misaligned addresses, through per-lane addressing and byte rotation. Out-of-range or illegal requests complete with an error and never touch the SRAM.

---
 rtl/dmemory_port.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dmemory_port.sv
// Data-side load/store port onto four byte-lane single-port SRAM macros.
// Misaligned accesses use per-lane word addresses plus byte rotation; illegal requests never touch SRAM.
module dmemory_port #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [3:0]         CEN,
  output logic [3:0]         GWEN,
  output logic [3:0][7:0]    WEN,
  output logic [3:0][AW-1:0] A,
  output logic [3:0][7:0]    D,
  input  logic [3:0][7:0]    Q
);
  // state   | meaning
  // IDLE    | accepting a request
  // ACCESS  | SRAM lanes enabled for one cycle
  // CAPTURE | load data on Q, registered into resp_rdata
  // RESP    | response held until resp_ready
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  localparam logic [32:0] LAST_BYTE = 33'(4 * DEPTH - 1);

  state_t              r_state;
  logic                r_we;
  logic                r_uns;
  logic [1:0]          r_size;
  logic [1:0]          r_off;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [3:0]          r_cen;
  logic [3:0]          r_gwen;
  logic [3:0][7:0]     r_wen;
  logic [3:0][AW-1:0]  r_a;
  logic [3:0][7:0]     r_d;

  logic [2:0]          w_n;
  logic [32:0]         w_end;
  logic                w_illegal;
  logic [3:0]          w_cen;
  logic [3:0]          w_gwen;
  logic [3:0][7:0]     w_wen;
  logic [3:0][AW-1:0]  w_a;
  logic [3:0][7:0]     w_d;
  logic [AW+1:0]       w_b;
  logic [3:0][7:0]     w_bytes;
  logic [1:0]          w_lane;
  logic                w_sign;
  logic [31:0]         w_load;

  always_comb begin
    case (req_size)
      2'd0:    w_n = 3'd1;
      2'd1:    w_n = 3'd2;
      2'd2:    w_n = 3'd4;
      default: w_n = 3'd0;
    endcase
  end

  // 33-bit end address so a request near 2^32 cannot wrap back into range
  assign w_end     = {1'b0, req_addr} + {30'd0, w_n} - 33'd1;
  assign w_illegal = (req_size == 2'd3) || (w_end > LAST_BYTE);

  always_comb begin
    w_cen  = '1;
    w_gwen = '1;
    w_wen  = '1;
    w_a    = '0;
    w_d    = '0;
    w_b    = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_n) begin
        w_b               = req_addr[AW+1:0] + (AW+2)'(k);
        w_cen[w_b[1:0]]   = 1'b0;
        w_gwen[w_b[1:0]]  = ~req_we;
        w_wen[w_b[1:0]]   = req_we ? 8'h00 : 8'hFF;
        w_a[w_b[1:0]]     = w_b[AW+1:2];
        w_d[w_b[1:0]]     = req_we ? req_wdata[8*k +: 8] : 8'h00;
      end
    end
  end

  // Rotate lanes back so byte k of the result comes from lane (offset + k)
  always_comb begin
    w_bytes = '0;
    w_lane  = '0;
    for (int k = 0; k < 4; k++) begin
      w_lane     = r_off + 2'(k);
      w_bytes[k] = Q[w_lane];
    end
    case (r_size)
      2'd0: begin
        w_sign = ~r_uns & w_bytes[0][7];
        w_load = {{24{w_sign}}, w_bytes[0]};
      end
      2'd1: begin
        w_sign = ~r_uns & w_bytes[1][7];
        w_load = {{16{w_sign}}, w_bytes[1], w_bytes[0]};
      end
      default: begin
        w_sign = 1'b0;
        w_load = w_bytes;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'd0;
      r_off   <= 2'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cen   <= '1;
      r_gwen  <= '1;
      r_wen   <= '1;
      r_a     <= '0;
      r_d     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_size  <= req_size;
            r_off   <= req_addr[1:0];
            r_rdata <= '0;
            if (w_illegal) begin
              r_err   <= 1'b1;
              r_state <= RESP;
            end else begin
              r_err   <= 1'b0;
              r_cen   <= w_cen;
              r_gwen  <= w_gwen;
              r_wen   <= w_wen;
              r_a     <= w_a;
              r_d     <= w_d;
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          r_cen   <= '1;
          r_gwen  <= '1;
          r_wen   <= '1;
          r_a     <= '0;
          r_d     <= '0;
          r_state <= r_we ? RESP : CAPTURE;
        end
        CAPTURE: begin
          r_rdata <= w_load;
          r_state <= RESP;
        end
        RESP: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset gates the chip enables directly so a store in flight cannot commit
  assign CEN        = r_cen | {4{rst}};
  assign GWEN       = r_gwen;
  assign WEN        = r_wen;
  assign A          = r_a;
  assign D          = r_d;
  assign req_ready  = (r_state == IDLE) && !rst;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
endmodule
